// File: rtl/rgb_pattern_source_if.sv
// rgb_pattern_source_if: control inputs and parallel RGB video outputs of the pattern source
interface rgb_pattern_source_if;
  logic        I_enable;
  logic [1:0]  I_pattern;
  logic        O_rgb_vs;
  logic        O_rgb_hs;
  logic        O_rgb_de;
  logic [7:0]  O_rgb_r;
  logic [7:0]  O_rgb_g;
  logic [7:0]  O_rgb_b;
  logic        O_frame_start;
  logic [15:0] O_frame_count;
  modport master (
    input  I_enable, I_pattern,
    output O_rgb_vs, O_rgb_hs, O_rgb_de, O_rgb_r, O_rgb_g, O_rgb_b, O_frame_start, O_frame_count
  );
  modport slave (
    output I_enable, I_pattern,
    input  O_rgb_vs, O_rgb_hs, O_rgb_de, O_rgb_r, O_rgb_g, O_rgb_b, O_frame_start, O_frame_count
  );
endinterface

// File: rtl/rgb_pattern_source.sv
// rgb_pattern_source: frame-aligned sync timing and test pattern generator for the DVI-style RGB bus
module rgb_pattern_source #(
  parameter int H_ACTIVE = 128,
  parameter int H_FRONT  = 4,
  parameter int H_SYNC   = 4,
  parameter int H_BACK   = 8,
  parameter int V_ACTIVE = 32,
  parameter int V_FRONT  = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 4,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input logic                  I_clk,
  input logic                  I_rst_n,
  rgb_pattern_source_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DE_END   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DE_END   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [1:0]  r_pattern;
  logic [15:0] r_frame_count;
  logic        w_active;
  logic        w_h_last;
  logic        w_last;
  logic        w_de;
  logic        w_hs_on;
  logic        w_vs_on;
  logic [7:0]  w_x;
  logic [7:0]  w_y;
  logic [7:0]  w_chk;
  logic [7:0]  w_r;
  logic [7:0]  w_g;
  logic [7:0]  w_b;

  assign w_active = r_state != IDLE;
  assign w_h_last = r_h == H_LAST;
  assign w_last   = w_h_last && r_v == V_LAST;

  // Next state: enable always wins; without it a running frame drains to its last cycle, then idles
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = bus.I_enable ? RUN : (w_active && !w_last) ? DRAIN : IDLE;
  end

  // State register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Raster counters, held at the origin while idle
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= (!w_active || w_h_last) ? '0 : r_h + HW'(1);
      r_v <= !w_active ? '0 : !w_h_last ? r_v : (r_v == V_LAST) ? '0 : r_v + VW'(1);
    end
  end

  // Pattern and frame counter only change on frame boundaries so every frame is self-consistent
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_pattern     <= '0;
      r_frame_count <= '0;
    end else begin
      if (!w_active || w_last) r_pattern <= bus.I_pattern;
      if (w_active && w_last) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign w_de    = w_active && r_h < H_DE_END && r_v < V_DE_END;
  assign w_hs_on = w_active && r_h >= H_SYNC_BEG && r_h < H_SYNC_END;
  assign w_vs_on = w_active && r_v >= V_SYNC_BEG && r_v < V_SYNC_END;
  assign w_x     = 8'(r_h);
  assign w_y     = 8'(r_v);
  assign w_chk   = {8{w_x[3] ^ w_y[3]}};

  // Pattern colour mux, blanked outside the active area
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    w_r = !w_de ? 8'h00 : r_pattern == 2'd0 ? w_x : r_pattern == 2'd2 ? w_chk : r_pattern == 2'd3 ? r_frame_count[7:0] : 8'h00;
    w_g = !w_de ? 8'h00 : r_pattern == 2'd1 ? w_y : r_pattern == 2'd2 ? w_chk : r_pattern == 2'd3 ? w_x : 8'h00;
    w_b = !w_de ? 8'h00 : r_pattern == 2'd2 ? w_chk : r_pattern == 2'd3 ? w_y : 8'h00;
  end

  // Output registers: pins show the previous cycle's counter/state decode
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      bus.O_rgb_vs      <= ~VS_POL;
      bus.O_rgb_hs      <= ~HS_POL;
      bus.O_rgb_de      <= 1'b0;
      bus.O_rgb_r       <= '0;
      bus.O_rgb_g       <= '0;
      bus.O_rgb_b       <= '0;
      bus.O_frame_start <= 1'b0;
      bus.O_frame_count <= '0;
    end else begin
      bus.O_rgb_vs      <= w_vs_on ? VS_POL : ~VS_POL;
      bus.O_rgb_hs      <= w_hs_on ? HS_POL : ~HS_POL;
      bus.O_rgb_de      <= w_de;
      bus.O_rgb_r       <= w_r;
      bus.O_rgb_g       <= w_g;
      bus.O_rgb_b       <= w_b;
      bus.O_frame_start <= w_active && r_h == '0 && r_v == '0;
      bus.O_frame_count <= r_frame_count;
    end
  end
endmodule

// File: tb/tb_rgb_pattern_source.sv
// tb_rgb_pattern_source: scoreboard bench driving enable/pattern scenarios against a position-based reference model
module tb_rgb_pattern_source;
  logic I_clk = 1'b0;
  logic I_rst_n = 1'b0;
  rgb_pattern_source_if bus();
  rgb_pattern_source dut (.I_clk(I_clk), .I_rst_n(I_rst_n), .bus(bus));
  always #5 I_clk = ~I_clk;

  typedef struct packed {
    logic vs, hs, de;
    logic [7:0] r, g, b;
    logic fs;
    logic [15:0] fc;
  } px_t;

  px_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int m_st = 0;
  int m_p = 0;
  logic [15:0] m_fc = 16'h0;
  logic [1:0] m_pat = 2'd0;
  logic m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference pixel for the model's current linear position within a 144x40 frame
  function automatic px_t model_px();
    px_t e;
    int x, y;
    logic c;
    e = '0;
    x = m_p % 144;
    y = m_p / 144;
    c = x[3] ^ y[3];
    if (m_st != 0) begin
      e.de = x < 128 && y < 32;
      e.hs = x >= 132 && x < 136;
      e.vs = y >= 34 && y < 36;
      e.fs = m_p == 0;
      if (e.de)
        case (m_pat)
          2'd0: e.r = x[7:0];
          2'd1: e.g = y[7:0];
          2'd2: {e.r, e.g, e.b} = {24{c}};
          default: begin e.r = m_fc[7:0]; e.g = x[7:0]; e.b = y[7:0]; end
        endcase
    end
    e.fc = m_fc;
    return e;
  endfunction

  always @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      m_st = 0; m_p = 0; m_fc = 16'h0; m_pat = 2'd0;
      sb.delete();
    end else begin
      sb.push_back(model_px());
      if (m_st == 0) begin
        m_pat = bus.I_pattern;
        m_st = bus.I_enable ? 1 : 0;
      end else begin
        m_last = m_p == 5759;
        if (m_last) begin
          m_fc = m_fc + 16'd1;
          m_pat = bus.I_pattern;
        end
        m_p = m_last ? 0 : m_p + 1;
        m_st = bus.I_enable ? 1 : m_last ? 0 : 2;
      end
    end
  end

  always @(negedge I_clk) begin
    px_t e;
    if (I_rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      check("vs", bus.O_rgb_vs, e.vs);
      check("hs", bus.O_rgb_hs, e.hs);
      check("de", bus.O_rgb_de, e.de);
      check("r", bus.O_rgb_r, e.r);
      check("g", bus.O_rgb_g, e.g);
      check("b", bus.O_rgb_b, e.b);
      check("frame_start", bus.O_frame_start, e.fs);
      check("frame_count", bus.O_frame_count, e.fc);
    end
  end

  task automatic wait_fs(input string tag);
    for (int t = 0; t < 20000 && bus.O_frame_start !== 1'b1; t++) @(negedge I_clk);
    check(tag, bus.O_frame_start, 1);
  endtask

  // Measure one whole frame from its frame_start; optionally change pattern or drop enable at output index ev_at
  task automatic measure_frame(input int ev_at, input bit drop, input logic [1:0] new_pat, input logic [1:0] pat);
    int de_n = 0, runs = 0, vs_n = 0, hs_n = 0, first_hs = -1, g_nz = 0, r_nz = 0;
    logic prev_de = 1'b0;
    wait_fs("fs_wait");
    for (int i = 0; i < 5760; i++) begin
      if (i == ev_at) begin
        if (drop) bus.I_enable = 1'b0;
        else bus.I_pattern = new_pat;
      end
      if (bus.O_rgb_de) de_n++;
      if (bus.O_rgb_de && !prev_de) runs++;
      prev_de = bus.O_rgb_de;
      if (bus.O_rgb_vs) vs_n++;
      if (bus.O_rgb_hs) begin
        hs_n++;
        if (first_hs < 0) first_hs = i;
      end
      if (bus.O_rgb_de && bus.O_rgb_g != 8'h00) g_nz++;
      if (bus.O_rgb_de && bus.O_rgb_r != 8'h00) r_nz++;
      if (pat == 2'd2 && i == 0)    check("chk_l0_x0", bus.O_rgb_r, 8'h00);
      if (pat == 2'd2 && i == 8)    check("chk_l0_x8", bus.O_rgb_r, 8'hFF);
      if (pat == 2'd2 && i == 1152) check("chk_l8_x0", bus.O_rgb_r, 8'hFF);
      if (pat == 2'd2 && i == 1160) check("chk_l8_x8", bus.O_rgb_r, 8'h00);
      @(negedge I_clk);
    end
    check("de_cycles", de_n, 4096);
    check("de_runs", runs, 32);
    check("vs_cycles", vs_n, 288);
    check("hs_cycles", hs_n, 160);
    check("hs_first", first_hs, 132);
    if (pat == 2'd0) check("p0_g_zero", g_nz, 0);
    if (pat == 2'd0) check("p0_r_used", r_nz > 0, 1);
    if (pat == 2'd1) check("p1_r_zero", r_nz, 0);
    if (pat == 2'd1) check("p1_g_used", g_nz > 0, 1);
    check("next_fs", bus.O_frame_start, !drop);
    if (drop) check("idle_de", bus.O_rgb_de, 0);
  endtask

  initial begin
    bus.I_enable = 1'b0;
    bus.I_pattern = 2'd0;
    #1;
    check("rst_vs", bus.O_rgb_vs, 0);
    check("rst_hs", bus.O_rgb_hs, 0);
    check("rst_de", bus.O_rgb_de, 0);
    check("rst_rgb", {bus.O_rgb_r, bus.O_rgb_g, bus.O_rgb_b}, 0);
    check("rst_fs", bus.O_frame_start, 0);
    check("rst_fc", bus.O_frame_count, 0);
    repeat (3) @(negedge I_clk);
    I_rst_n = 1'b1;
    repeat (1000) @(negedge I_clk);
    check("idle_fc", bus.O_frame_count, 0);
    bus.I_pattern = 2'd2;
    bus.I_enable = 1'b1;
    @(negedge I_clk);
    check("start_no_de_yet", bus.O_rgb_de, 0);
    @(negedge I_clk);
    check("start_de", bus.O_rgb_de, 1);
    check("start_fs", bus.O_frame_start, 1);
    measure_frame(100, 1'b0, 2'd0, 2'd2);
    measure_frame(5 * 144 + 10, 1'b0, 2'd1, 2'd0);
    measure_frame(10, 1'b0, 2'd3, 2'd1);
    measure_frame(16 * 144 + 64, 1'b1, 2'd0, 2'd3);
    check("fc_after_drain", bus.O_frame_count, 4);
    repeat (20) @(negedge I_clk);
    check("idle_hold_fc", bus.O_frame_count, 4);
    bus.I_enable = 1'b1;
    wait_fs("restart_fs");
    repeat (200) @(negedge I_clk);
    bus.I_enable = 1'b0;
    repeat (300) @(negedge I_clk);
    bus.I_enable = 1'b1;
    measure_frame(-1, 1'b0, 2'd0, 2'd3);
    repeat (10) @(negedge I_clk);
    force dut.r_frame_count = 16'hFFFF;
    m_fc = 16'hFFFF;
    @(negedge I_clk);
    release dut.r_frame_count;
    @(negedge I_clk);
    wait_fs("wrap_fs");
    check("fc_wrap", bus.O_frame_count, 0);
    for (int t = 0; t < 20000 && !(m_p % 144 == 40 && m_p / 144 == 3); t++) @(negedge I_clk);
    check("pre_rst_de", bus.O_rgb_de, 1);
    #2;
    I_rst_n = 1'b0;
    bus.I_enable = 1'b0;
    #1;
    check("arst_vs", bus.O_rgb_vs, 0);
    check("arst_hs", bus.O_rgb_hs, 0);
    check("arst_de", bus.O_rgb_de, 0);
    check("arst_rgb", {bus.O_rgb_r, bus.O_rgb_g, bus.O_rgb_b}, 0);
    check("arst_fs", bus.O_frame_start, 0);
    check("arst_fc", bus.O_frame_count, 0);
    @(negedge I_clk);
    I_rst_n = 1'b1;
    repeat (50) @(negedge I_clk);
    check("post_rst_de", bus.O_rgb_de, 0);
    check("post_rst_fc", bus.O_frame_count, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
